// File: rtl/block_match_sched_multi.sv
// block_match_sched_multi: walks the disparity-block grid of a frame and dispatches blocks to NUM_ENG engines.
// Define BM_SCHED_PERF_EN to report the busy cycles of each frame on perf_cycles (tied to 0 otherwise).
module block_match_sched_multi #(
    parameter int RD_PORT_W  = 8,
    parameter int FRAME_W    = 960,
    parameter int FRAME_H    = 540,
    parameter int BLOCK_SIZE = 16,
    parameter int SEARCH_W   = 64,
    parameter int SEARCH_H   = 32,
    parameter int STRIDE     = 16,
    parameter int NUM_ENG    = 2,
    parameter int BUF_BITS   = 1,
    parameter int ADDR_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  img_number_in,
    input  logic [NUM_ENG-1:0]          eng_done,
    output logic [NUM_ENG-1:0]          eng_start,
    output logic [NUM_ENG*ADDR_W-1:0]   srch_addr,
    output logic [NUM_ENG*ADDR_W-1:0]   blk_addr_left,
    output logic [NUM_ENG*ADDR_W-1:0]   blk_addr_right,
    output logic [NUM_ENG*16-1:0]       blk_index,
    output logic                        bm_idle,
    output logic [BUF_BITS-1:0]         bm_working_buf,
    output logic                        frame_done,
    output logic [31:0]                 perf_cycles
);
    localparam int FAW      = FRAME_W / RD_PORT_W;
    localparam int SAW      = STRIDE / RD_PORT_W;
    localparam int BAW      = BLOCK_SIZE / RD_PORT_W;
    localparam int WAW      = SEARCH_W / RD_PORT_W;
    localparam int COLS     = (FRAME_W - SEARCH_W) / STRIDE;
    localparam int ROWS     = (FRAME_H - SEARCH_H) / STRIDE;
    localparam int ROW_STEP = FAW * STRIDE;
    localparam int R_OFF    = FAW * ((SEARCH_H - BLOCK_SIZE) / 2);
    localparam int L_OFF    = R_OFF + WAW - BAW;
    localparam int LW       = ADDR_W - BUF_BITS;
    localparam logic [LW-1:0] ROW_STEP_V = LW'(ROW_STEP);
    localparam logic [LW-1:0] SAW_V      = LW'(SAW);
    localparam logic [LW-1:0] R_OFF_V    = LW'(R_OFF);
    localparam logic [LW-1:0] L_OFF_V    = LW'(L_OFF);

    if (COLS < 1 || COLS > 64 || ROWS < 1 || ROWS > 64 || STRIDE % RD_PORT_W != 0 ||
        NUM_ENG < 1 || NUM_ENG > 8) begin : g_param_err
        $error("block_match_sched_multi: unsupported geometry parameters");
    end

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;
    state_t state, state_nxt;

    logic [3:0]         img_number;
    logic [5:0]         row, col;
    logic [LW-1:0]      row_base, col_off, base;
    logic [NUM_ENG-1:0] free, grant;
    logic               all_free, last, start_frame, dispatch, fin;

    // eng_start doubles as the per-slot LAUNCH flag; BUSY is simply eng_done low after launch
    assign free      = eng_done & ~eng_start;
    assign grant     = free & (~free + NUM_ENG'(1));
    assign all_free  = &free;
    assign base      = row_base + col_off;
    assign last      = (row == 6'(ROWS - 1)) && (col == 6'(COLS - 1));
    assign bm_idle   = (state == IDLE) && all_free;
    assign bm_working_buf = img_number[BUF_BITS-1:0];

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        dispatch    = 1'b0;
        fin         = 1'b0;
        case (state)
            IDLE: if (img_number_in != img_number && all_free) begin
                state_nxt   = DISPATCH;
                start_frame = 1'b1;
            end
            DISPATCH: if (|free) begin
                dispatch  = 1'b1;
                state_nxt = last ? DRAIN : DISPATCH;
            end
            DRAIN: if (all_free) begin
                fin       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            img_number     <= '0;
            row            <= '0;
            col            <= '0;
            row_base       <= '0;
            col_off        <= '0;
            eng_start      <= '0;
            srch_addr      <= '0;
            blk_addr_left  <= '0;
            blk_addr_right <= '0;
            blk_index      <= '0;
            frame_done     <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= fin;
            if (fin)
                img_number <= img_number + 4'd1;
            if (start_frame) begin
                row      <= '0;
                col      <= '0;
                row_base <= '0;
                col_off  <= '0;
            end else if (dispatch) begin
                if (col == 6'(COLS - 1)) begin
                    col      <= '0;
                    col_off  <= '0;
                    row      <= row + 6'd1;
                    row_base <= row_base + ROW_STEP_V;
                end else begin
                    col     <= col + 6'd1;
                    col_off <= col_off + SAW_V;
                end
            end
            for (int i = 0; i < NUM_ENG; i++) begin
                if (dispatch && grant[i]) begin
                    eng_start[i]                       <= 1'b1;
                    srch_addr[i*ADDR_W +: ADDR_W]      <= {img_number[BUF_BITS-1:0], base};
                    blk_addr_left[i*ADDR_W +: ADDR_W]  <= {img_number[BUF_BITS-1:0], base + L_OFF_V};
                    blk_addr_right[i*ADDR_W +: ADDR_W] <= {img_number[BUF_BITS-1:0], base + R_OFF_V};
                    blk_index[i*16 +: 16]              <= {img_number, row, col};
                end else if (!eng_done[i]) begin
                    eng_start[i] <= 1'b0;
                end
            end
        end
    end

`ifdef BM_SCHED_PERF_EN
    logic [31:0] cnt, cnt_inc;

    assign cnt_inc = &cnt ? cnt : cnt + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            perf_cycles <= '0;
        end else begin
            cnt <= (state == IDLE) ? '0 : cnt_inc;
            if (fin)
                perf_cycles <= cnt_inc;
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_block_match_sched_multi.sv
// tb_block_match_sched_multi: randomized engine timing against a grid-walk reference model.
module tb_block_match_sched_multi;
    localparam int NE   = 2;
    localparam int AW   = 16;
    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int NBLK = COLS * ROWS;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        img_number_in;
    logic [NE-1:0]     eng_done;
    logic [NE-1:0]     eng_start;
    logic [NE*AW-1:0]  srch_addr, blk_addr_left, blk_addr_right;
    logic [NE*16-1:0]  blk_index;
    logic              bm_idle;
    logic [0:0]        bm_working_buf;
    logic              frame_done;
    logic [31:0]       perf_cycles;

    int vectors = 0;
    int miscompares = 0;

    block_match_sched_multi #(
        .FRAME_W(128), .FRAME_H(64), .SEARCH_W(64), .SEARCH_H(32),
        .BLOCK_SIZE(16), .STRIDE(16), .NUM_ENG(NE)
    ) dut (
        .clk(clk), .reset(reset), .img_number_in(img_number_in),
        .eng_done(eng_done), .eng_start(eng_start), .srch_addr(srch_addr),
        .blk_addr_left(blk_addr_left), .blk_addr_right(blk_addr_right),
        .blk_index(blk_index), .bm_idle(bm_idle), .bm_working_buf(bm_working_buf),
        .frame_done(frame_done), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // engine timing: ack = extra samples eng_done stays high once start is seen, work = samples it stays low
    int ack[NE], work[NE];
    int ph[NE], cnt[NE], hold[NE], ack_used[NE], fcnt[NE], last_cnt[NE];
    bit first2[NE];
    int k = 0, model_img = 0, frames = 0, total_disp = 0, cyc = 0, t_start = 0;

    initial begin
        eng_done = '1;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                eng_done  = '1;
                k         = 0;
                model_img = 0;
                for (int e = 0; e < NE; e++) begin
                    ph[e]   = 0;
                    fcnt[e] = 0;
                end
            end else begin
                for (int e = 0; e < NE; e++) begin
                    if (ph[e] == 0) begin
                        if (eng_start[e]) begin
                            int r, c, b, bufv;
                            r    = k / COLS;
                            c    = k % COLS;
                            b    = r * 256 + c * 2;
                            bufv = model_img % 2;
                            check("blk_count", (k < NBLK) ? 1 : 0, 1);
                            check("srch_addr", srch_addr[e*AW +: AW], bufv * 32768 + (b % 32768));
                            check("blk_left", blk_addr_left[e*AW +: AW], bufv * 32768 + ((b + 134) % 32768));
                            check("blk_right", blk_addr_right[e*AW +: AW], bufv * 32768 + ((b + 128) % 32768));
                            check("blk_index", blk_index[e*16 +: 16], (model_img % 16) * 4096 + r * 64 + c);
                            if (k == 0) t_start = cyc;
                            k++;
                            total_disp++;
                            fcnt[e]++;
                            ph[e]       = 1;
                            cnt[e]      = ack[e];
                            ack_used[e] = ack[e];
                            hold[e]     = 1;
                        end
                    end else if (ph[e] == 1) begin
                        if (eng_start[e]) hold[e]++;
                        cnt[e]--;
                        if (cnt[e] == 0) begin
                            eng_done[e] = 1'b0;
                            cnt[e]      = work[e];
                            ph[e]       = 2;
                            first2[e]   = 1'b1;
                        end
                    end else begin
                        if (first2[e]) begin
                            if (eng_start[e]) hold[e]++;
                            check("start_hold", hold[e], ack_used[e] + 1);
                            first2[e] = 1'b0;
                        end
                        cnt[e]--;
                        if (cnt[e] == 0) begin
                            eng_done[e] = 1'b1;
                            ph[e]       = 0;
                        end
                    end
                end
                if (frame_done) begin
                    check("frame_blocks", k, NBLK);
                    check("drain_idle", ((ph[0] == 0) && (ph[1] == 0)) ? 1 : 0, 1);
                    check("working_buf", bm_working_buf, (model_img + 1) % 2);
`ifdef BM_SCHED_PERF_EN
                    check("perf_cycles", perf_cycles, cyc - t_start + 1);
`else
                    check("perf_cycles", perf_cycles, 0);
`endif
                    model_img = (model_img + 1) % 16;
                    k = 0;
                    frames++;
                    for (int e = 0; e < NE; e++) begin
                        last_cnt[e] = fcnt[e];
                        fcnt[e]     = 0;
                    end
                end
            end
        end
    end

    task automatic set_lat(input int a0, input int w0, input int a1, input int w1);
        ack[0] = a0; work[0] = w0; ack[1] = a1; work[1] = w1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", (frames >= target) ? 1 : 0, 1);
    endtask

    initial begin
        int n;
        img_number_in = 4'd0;
        set_lat(1, 5, 1, 5);
        do_reset();
        @(negedge clk);
        check("rst_idle", bm_idle, 1);
        check("rst_start", eng_start, 0);
        check("rst_done", frame_done, 0);
        check("rst_buf", bm_working_buf, 0);
        check("rst_perf", perf_cycles, 0);
        repeat (20) @(negedge clk);
        check("no_dispatch", total_disp, 0);
        check("still_idle", bm_idle, 1);

        // one frame, uniform fast engines
        img_number_in = 4'd1;
        repeat (3) @(negedge clk);
        check("busy_not_idle", bm_idle, 0);
        wait_frames(1);
        repeat (10) @(negedge clk);
        check("single_frame", frames, 1);
        check("idle_after", bm_idle, 1);

        // engine 1 slow: engine 0 absorbs every block after the first two
        set_lat(1, 2, 1, 60);
        img_number_in = 4'd2;
        wait_frames(2);
        check("slow_eng1_cnt", last_cnt[1], 1);
        check("fast_eng0_cnt", last_cnt[0], NBLK - 1);

        // engine 0 acknowledges late
        set_lat(3, 2, 1, 3);
        img_number_in = 4'd3;
        wait_frames(3);

        for (int i = 0; i < 4; i++) begin
            set_lat($urandom_range(1, 3), $urandom_range(1, 12), $urandom_range(1, 3), $urandom_range(1, 12));
            img_number_in = img_number_in + 4'd1;
            wait_frames(frames + 1);
        end

        // reset while the third block is still launching
        img_number_in = 4'd0;
        set_lat(3, 4, 3, 4);
        do_reset();
        img_number_in = 4'd1;
        n = 0;
        while (k < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("third_launch", (k >= 3) ? 1 : 0, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_start", eng_start, 0);
        check("mid_rst_srch", srch_addr, 0);
        check("mid_rst_left", blk_addr_left, 0);
        check("mid_rst_right", blk_addr_right, 0);
        check("mid_rst_index", blk_index, 0);
        check("mid_rst_done", frame_done, 0);
        check("mid_rst_perf", perf_cycles, 0);
        check("mid_rst_buf", bm_working_buf, 0);
        @(negedge clk);
        check("mid_rst_idle", bm_idle, 1);
        reset = 1'b0;
        wait_frames(frames + 1);

        // writer two frames ahead: both processed in order
        set_lat(1, 3, 2, 5);
        img_number_in = 4'd0;
        do_reset();
        img_number_in = 4'd2;
        n = frames;
        wait_frames(n + 2);
        repeat (20) @(negedge clk);
        check("two_frames", frames - n, 2);
        check("caught_up_idle", bm_idle, 1);
        check("caught_up_buf", bm_working_buf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
